dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width (1024-word data memory).
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset: synchronous, active-low.
REQ-005 core_req  in  1  core load/store request; held with core_we/addr/wdata stable until core_gnt.
REQ-006 core_we  in  1  1=store, 0=load.
REQ-007 core_addr  in  ADDR_W  core word address.
REQ-008 core_wdata  in  DATA_W  core store data.
REQ-009 core_gnt  out  1  one-cycle pulse: core request accepted.
REQ-010 core_rvalid  out  1  one-cycle pulse: core access complete.
REQ-011 core_rdata  out  DATA_W  load data, valid with core_rvalid.
REQ-012 ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_W/DATA_W  loader/debug requester, same rules as core_*.
REQ-013 ldr_gnt, ldr_rvalid, ldr_rdata  out  1/1/DATA_W  loader responses, same rules as core_*.
REQ-014 mem_en  out  1  memory access strobe.
REQ-015 mem_we  out  1  memory write enable, qualified by mem_en.
REQ-016 mem_addr  out  ADDR_W  memory word address.
REQ-017 mem_wdata  out  DATA_W  memory write data.
REQ-018 mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-019 FSM states IDLE, ISSUE, RESP; IDLE->ISSUE when any req, ISSUE->RESP always, RESP->IDLE always.
REQ-020 In IDLE with a request, winner's we/addr/wdata and owner id latched; winner's gnt asserted in ISSUE for exactly one cycle.
REQ-021 In ISSUE: mem_en=1, mem_we/addr/wdata driven from latched values; otherwise mem_en=0, mem_we=0, mem_addr/mem_wdata hold last value.
REQ-022 In RESP: owner's rvalid=1 for one cycle; owner's rdata=mem_rdata for loads, 0 for stores; non-owner rvalid=0.
REQ-023 Latency: request seen in IDLE at cycle N -> gnt at N+1, mem_en at N+1, rvalid at N+2; max throughput one access per 3 cycles.
REQ-024 Single requester: granted regardless of round-robin pointer.
REQ-025 Both requesting in IDLE: requester not granted last wins (round-robin); last_owner updated on every grant.
REQ-026 Request deasserted after latch (in ISSUE/RESP) has no effect; access completes.
REQ-027 Requester holding req through RESP is re-arbitrated in the following IDLE cycle as a new request.
REQ-028 rdata outputs 0 whenever the respective rvalid=0.
REQ-029 Never more than one gnt or one rvalid asserted in a cycle; never gnt and mem_en out of step.

Reset
REQ-030 rst=0 at a rising edge: state=IDLE, last_owner=LDR (core wins first tie), latched regs=0.
REQ-031 Outputs during/after reset: all gnt/rvalid=0, all rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset mid-transaction aborts it: no rvalid issued for the aborted access.

Structure
REQ-033 Package dmem_arb_pkg holds ADDR_W/DATA_W defaults, state enum (IDLE, ISSUE, RESP) and owner enum (OWN_CORE, OWN_LDR).
REQ-034 One sub-module rr_pick2: combinational two-way round-robin picker (req[1:0], last_owner -> winner, any).

Verification
REQ-035 Core load addr 5, mem[5]=0x4: core_gnt cycle N+1, mem_en/mem_addr=5 cycle N+1, core_rvalid with core_rdata=0x4 cycle N+2.
REQ-036 Loader store addr 12 data 0xDEADBEEF: mem_we=1, mem_addr=12, mem_wdata=0xDEADBEEF in ISSUE; ldr_rvalid=1, ldr_rdata=0 in RESP.
REQ-037 Both request continuously from reset: grants alternate core, ldr, core, ldr, one every 3 cycles.
REQ-038 Core request at address 1023 then 0: both complete with correct addresses, no wrap error.
REQ-039 rst=0 asserted in RESP of a core load: no core_rvalid, all outputs 0 next cycle, first post-reset tie goes to core.
REQ-040 Core drops core_req in ISSUE: access still completes with core_rvalid in RESP, no second grant.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// The core and the loader/debug port share one single-port data memory;
// the FSM and owner encodings below are used by the top and the picker.
package dmem_arb_pkg;

   // Default geometry: 1024 words of 32 bits
   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 32;

   // Arbiter FSM: one memory access takes exactly IDLE -> ISSUE -> RESP
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Which requester owns the access currently in flight
   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_LDR  = 1'b1
   } owner_t;

   // Request vector bit positions handed to the picker
   localparam int REQ_CORE = 0;
   localparam int REQ_LDR  = 1;

   // The owner that did not win last time; used to break a tie
   function automatic owner_t other_owner(input owner_t o);
      return (o == OWN_CORE) ? OWN_LDR : OWN_CORE;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker.
// A lone requester always wins. When both request, the one that was not
// granted last time wins. Purely combinational; the caller keeps the
// last-owner pointer.
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic       winner,
   output logic       any
);

   // Select the winner from the request vector and the last grant
   always_comb begin
      any    = req[REQ_CORE] | req[REQ_LDR];
      winner = OWN_CORE;
      if (req[REQ_CORE] && req[REQ_LDR]) begin
         winner = other_owner(owner_t'(last_owner));
      end else if (req[REQ_LDR]) begin
         winner = OWN_LDR;
      end else begin
         winner = OWN_CORE;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous single-port memory between
// the core and a loader/debug requester.
//
// Handshake: a requester raises *_req with we/addr/wdata stable and keeps
// them stable until it sees its one-cycle *_gnt pulse. The request is
// sampled in IDLE; the gnt pulse appears the following cycle (ISSUE) in
// step with mem_en, and the one-cycle *_rvalid pulse (with *_rdata for
// loads, 0 for stores) appears the cycle after that (RESP). Dropping req
// after it was sampled does not cancel the access. A req still high in
// RESP is seen again as a fresh request in the next IDLE cycle.
//
// All outputs are forced to their idle values while rst is low, so a
// reset arriving in RESP suppresses the pending rvalid.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,

   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic [1:0]        dbg_state
);

   state_t              state_q;
   state_t              state_d;
   owner_t              owner_q;
   owner_t              last_owner_q;
   logic                lat_we_q;
   logic [ADDR_W-1:0]   lat_addr_q;
   logic [DATA_W-1:0]   lat_wdata_q;

   logic [1:0]          req_vec;
   logic                pick_winner;
   logic                pick_any;
   logic                take;

   logic                in_issue;
   logic                in_resp;
   logic [DATA_W-1:0]   resp_data;

   assign req_vec[REQ_CORE] = core_req;
   assign req_vec[REQ_LDR]  = ldr_req;

   rr_pick2 u_pick (
      .req        (req_vec),
      .last_owner (last_owner_q),
      .winner     (pick_winner),
      .any        (pick_any)
   );

   // A request is only accepted while idle
   assign take = (state_q == IDLE) && pick_any;

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: every accepted request walks IDLE -> ISSUE -> RESP -> IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_any) state_d = ISSUE;
         ISSUE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Capture the winner's access and update the round-robin pointer
   always_ff @(posedge clk) begin
      if (!rst) begin
         owner_q      <= OWN_CORE;
         last_owner_q <= OWN_LDR;
         lat_we_q     <= 1'b0;
         lat_addr_q   <= '0;
         lat_wdata_q  <= '0;
      end else if (take) begin
         owner_q      <= owner_t'(pick_winner);
         last_owner_q <= owner_t'(pick_winner);
         if (pick_winner == OWN_LDR) begin
            lat_we_q    <= ldr_we;
            lat_addr_q  <= ldr_addr;
            lat_wdata_q <= ldr_wdata;
         end else begin
            lat_we_q    <= core_we;
            lat_addr_q  <= core_addr;
            lat_wdata_q <= core_wdata;
         end
      end
   end

   // Phase decode, blanked while reset is held
   assign in_issue  = rst && (state_q == ISSUE);
   assign in_resp   = rst && (state_q == RESP);
   assign resp_data = lat_we_q ? '0 : mem_rdata;

   // Memory port: address/data follow the latch, so they hold between accesses
   always_comb begin
      mem_en    = in_issue;
      mem_we    = in_issue && lat_we_q;
      mem_addr  = '0;
      mem_wdata = '0;
      if (rst) begin
         mem_addr  = lat_addr_q;
         mem_wdata = lat_wdata_q;
      end
   end

   // Requester responses: gnt in ISSUE, rvalid/rdata in RESP, owner only
   always_comb begin
      core_gnt    = 1'b0;
      ldr_gnt     = 1'b0;
      core_rvalid = 1'b0;
      ldr_rvalid  = 1'b0;
      core_rdata  = '0;
      ldr_rdata   = '0;
      if (owner_q == OWN_LDR) begin
         ldr_gnt    = in_issue;
         ldr_rvalid = in_resp;
         if (in_resp) ldr_rdata = resp_data;
      end else begin
         core_gnt    = in_issue;
         core_rvalid = in_resp;
         if (in_resp) core_rdata = resp_data;
      end
   end

   // Debug view of the FSM state
   assign dbg_state = state_q;

endmodule
